// File: rtl/spi_frame_seq_pkg.sv
// Shared definitions for the SPI frame sequencer: FSM states, fill byte and
// the width helper for the chip-select delay counter.
package spi_frame_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_HOLD    = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  localparam logic [7:0] FILL_BYTE      = 8'hFF;
  localparam int         CS_DLY_DEFAULT = 4;

  // The delay counter only has to reach CS_DLY-1.
  function automatic int dly_cnt_width(input int dly);
    return (dly <= 2) ? 1 : $clog2(dly);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is visible on
// data_o whenever empty_o is low.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count need a known value, and a reset-free array maps to RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_seq.sv
// Multi-byte SPI transaction sequencer: frames CS_N around LEN bytes fed one
// at a time to SPI_cont and collects the returned bytes into an RX FIFO.
module spi_frame_seq
  import spi_frame_seq_pkg::*;
#(
  parameter int         ADDR_WIDTH = 4,
  parameter int         LEN_WIDTH  = 8,
  parameter int         CS_DLY     = CS_DLY_DEFAULT,
  parameter logic [7:0] FILL       = FILL_BYTE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TX_STB,
  input  logic [7:0]           TX_DATA,
  output logic                 TX_FULL,
  input  logic                 RX_STB,
  output logic [7:0]           RX_DATA,
  output logic                 RX_EMPTY,
  output logic                 RX_OVF,
  input  logic                 START,
  input  logic [LEN_WIDTH-1:0] LEN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 CS_N,
  output logic                 SPI_W_STB,
  output logic [7:0]           SPI_W_DATA,
  input  logic                 SPI_W_READY,
  input  logic                 SPI_R_STB,
  input  logic [7:0]           SPI_R_DATA
);

  localparam int             DLY_W    = dly_cnt_width(CS_DLY);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(CS_DLY - 1);

  state_e               state_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic [DLY_W-1:0]     dly_q;
  logic                 cs_n_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 w_stb_q;
  logic [7:0]           w_data_q;
  logic                 rx_ovf_q;

  logic       tx_pop;
  logic       tx_empty;
  logic [7:0] tx_head;
  logic       rx_push;
  logic       rx_full;
  logic       rx_drop;

  sync_fifo #(.WIDTH(8), .ADDR_WIDTH(ADDR_WIDTH)) u_tx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (TX_STB),
    .data_i  (TX_DATA),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (TX_FULL),
    .empty_o (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .ADDR_WIDTH(ADDR_WIDTH)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (rx_push),
    .data_i  (SPI_R_DATA),
    .pop_i   (RX_STB),
    .data_o  (RX_DATA),
    .full_o  (rx_full),
    .empty_o (RX_EMPTY)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      ST_SEND:    tx_pop  = SPI_W_READY && !tx_empty;
      ST_WAIT_RX: rx_push = SPI_R_STB;
      default:    ;
    endcase
  end

  assign rx_drop = rx_push && rx_full && !(RX_STB && !RX_EMPTY);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      dly_q       <= '0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_stb_q     <= 1'b0;
      w_data_q    <= '0;
      rx_ovf_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      w_stb_q  <= 1'b0;
      w_data_q <= '0;
      if (rx_drop) rx_ovf_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (START) begin
            busy_q <= 1'b1;
            if (LEN != '0) begin
              remaining_q <= LEN;
              rx_ovf_q    <= 1'b0;
              cs_n_q      <= 1'b0;
              dly_q       <= '0;
              state_q     <= ST_SETUP;
            end else begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_SETUP: begin
          if (dly_q == DLY_LAST) begin
            dly_q   <= '0;
            state_q <= ST_SEND;
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        ST_SEND: begin
          if (SPI_W_READY) begin
            w_stb_q  <= 1'b1;
            w_data_q <= tx_empty ? FILL : tx_head;
            state_q  <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          if (SPI_R_STB) begin
            remaining_q <= remaining_q - 1'b1;
            dly_q       <= '0;
            state_q     <= (remaining_q == LEN_WIDTH'(1)) ? ST_HOLD : ST_SEND;
          end
        end
        ST_HOLD: begin
          if (dly_q == DLY_LAST) begin
            dly_q   <= '0;
            cs_n_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign CS_N       = cs_n_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign SPI_W_STB  = w_stb_q;
  assign SPI_W_DATA = w_data_q;
  assign RX_OVF     = rx_ovf_q;

endmodule

// File: tb/tb_spi_frame_seq.sv
// Bench for spi_frame_seq: a cycle model of SPI_cont (TICK divider 5) with a
// 16-bit MISO slave register, plus a queue-based reference of the frame rules.
module tb_spi_frame_seq;

  localparam int CS_DLY = 4;
  localparam int TICK   = 5;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_stb;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       rx_stb;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_ovf;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic       cs_n;
  logic       spi_w_stb;
  logic [7:0] spi_w_data;
  logic       spi_w_ready;
  logic       spi_r_stb;
  logic [7:0] spi_r_data;

  always #5 clk = ~clk;

  spi_frame_seq #(
    .ADDR_WIDTH (4),
    .LEN_WIDTH  (8),
    .CS_DLY     (CS_DLY),
    .FILL       (8'hFF)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .TX_STB      (tx_stb),
    .TX_DATA     (tx_data),
    .TX_FULL     (tx_full),
    .RX_STB      (rx_stb),
    .RX_DATA     (rx_data),
    .RX_EMPTY    (rx_empty),
    .RX_OVF      (rx_ovf),
    .START       (start),
    .LEN         (len),
    .BUSY        (busy),
    .DONE        (done),
    .CS_N        (cs_n),
    .SPI_W_STB   (spi_w_stb),
    .SPI_W_DATA  (spi_w_data),
    .SPI_W_READY (spi_w_ready),
    .SPI_R_STB   (spi_r_stb),
    .SPI_R_DATA  (spi_r_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: TX/RX FIFO contents, slave history and the overflow flag.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] m_hist[$];
  logic [7:0] exp_sent[$];
  int         m_rxi = 0;
  logic       m_ovf = 1'b0;

  function automatic void model_reset();
    m_tx.delete();
    m_rx.delete();
    m_hist.delete();
    m_rxi = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (m_tx.size() < DEPTH) m_tx.push_back(b);
  endfunction

  // Slave returns 0x29, 0x63, then echoes MOSI two bytes late.
  function automatic void model_frame(input int n);
    logic [7:0] b;
    logic [7:0] r;
    if (n != 0) m_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = (m_tx.size() != 0) ? m_tx.pop_front() : 8'hFF;
      exp_sent.push_back(b);
      r = (m_rxi == 0) ? 8'h29 : (m_rxi == 1) ? 8'h63 : m_hist[m_rxi - 2];
      m_hist.push_back(b);
      m_rxi++;
      if (m_rx.size() < DEPTH) m_rx.push_back(r);
      else m_ovf = 1'b1;
    end
  endfunction

  // Monitor, sampled on the falling edge.
  logic [7:0] sent_q[$];
  int done_cnt = 0;
  int wstb_cnt = 0;
  int cs_fall_cnt = 0;
  int proto_err = 0;

  initial begin : monitor
    int   cyc;
    int   cs_fall_cyc;
    int   last_rstb_cyc;
    bit   first_w_pending;
    logic cs_n_prev;
    cyc = 0; cs_fall_cyc = 0; last_rstb_cyc = 0; first_w_pending = 1'b0; cs_n_prev = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cnt++;
        if (!cs_n) proto_err++;
      end
      if (spi_w_stb) begin
        sent_q.push_back(spi_w_data);
        wstb_cnt++;
        if (cs_n) proto_err++;
        if (first_w_pending) begin
          if (cyc - cs_fall_cyc < CS_DLY) proto_err++;
          first_w_pending = 1'b0;
        end
      end else if (spi_w_data != 8'h00) begin
        proto_err++;
      end
      if (!cs_n && !busy) proto_err++;
      if (cs_n_prev && !cs_n) begin
        cs_fall_cnt++;
        cs_fall_cyc = cyc;
        first_w_pending = 1'b1;
      end
      if (!cs_n_prev && cs_n && !rst && (cyc - last_rstb_cyc < CS_DLY)) proto_err++;
      if (spi_r_stb) last_rstb_cyc = cyc;
      cs_n_prev = cs_n;
    end
  end

  // SPI_cont stand-in: one byte takes 16 half-periods of TICK clocks.
  initial begin : spi_model
    logic [15:0] sr;
    logic [7:0]  mo;
    logic [7:0]  mi;
    int          t;
    bit          active;
    sr = 16'h2963; mo = 8'h00; mi = 8'h00; t = 0; active = 1'b0;
    spi_w_ready = 1'b1; spi_r_stb = 1'b0; spi_r_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sr = 16'h2963; active = 1'b0;
        spi_w_ready = 1'b1; spi_r_stb = 1'b0; spi_r_data = 8'h00;
      end else begin
        if (spi_w_stb && !spi_w_ready) proto_err++;
        if (spi_r_stb) begin
          spi_r_stb = 1'b0; spi_r_data = 8'h00; spi_w_ready = 1'b1;
        end else if (active) begin
          t++;
          if (t % (2 * TICK) == TICK) mi = {mi[6:0], sr[15]};
          else if (t % (2 * TICK) == 0) begin
            sr = {sr[14:0], mo[7]};
            mo = {mo[6:0], 1'b0};
          end
          if (t == 16 * TICK) begin
            active = 1'b0; spi_r_stb = 1'b1; spi_r_data = mi;
          end
        end else if (spi_w_stb) begin
          mo = spi_w_data; mi = 8'h00; t = 0; active = 1'b1; spi_w_ready = 1'b0;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit to_model);
    tx_stb = 1'b1;
    tx_data = b;
    tick();
    tx_stb = 1'b0;
    if (to_model) model_push(b);
  endtask

  task automatic drain(input string name, input int exp_n);
    int n;
    logic [7:0] e;
    n = 0;
    while (!rx_empty && n < 40) begin
      e = (m_rx.size() != 0) ? m_rx.pop_front() : 8'h00;
      check({name, "_rx_data"}, 32'(rx_data), 32'(e));
      rx_stb = 1'b1;
      tick();
      rx_stb = 1'b0;
      n++;
    end
    check({name, "_rx_count"}, 32'(n), 32'(exp_n));
  endtask

  task automatic begin_frame(input int n, output int d0, output int f0);
    sent_q.delete();
    exp_sent.delete();
    d0 = done_cnt;
    f0 = cs_fall_cnt;
    model_frame(n);
    start = 1'b1;
    len = 8'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int n, input int d0, input int f0);
    int i;
    i = 0;
    while (done_cnt == d0 && i < 3000) begin
      tick();
      i++;
    end
    repeat (150) tick();
    check({name, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_cs_n"}, 32'(cs_n), 32'd1);
    check({name, "_cs_falls"}, 32'(cs_fall_cnt - f0), (n != 0) ? 32'd1 : 32'd0);
    check({name, "_sent_n"}, 32'(sent_q.size()), 32'(exp_sent.size()));
    for (int k = 0; k < exp_sent.size() && k < sent_q.size(); k++)
      check({name, "_sent_byte"}, 32'(sent_q[k]), 32'(exp_sent[k]));
    check({name, "_ovf"}, 32'(rx_ovf), 32'(m_ovf));
  endtask

  typedef struct {
    logic [7:0] first;
    logic [7:0] step;
    int         n_push;
    int         len;
    bit         drain;
    bit         exp_full;
    int         exp_rx;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int d0;
    int f0;
    int w0;
    int lim;
    logic [7:0] extra[4];
    logic [7:0] e;

    vecs[0] = '{first: 8'hAB, step: 8'h22, n_push: 2,  len: 2,  drain: 1'b1, exp_full: 1'b0, exp_rx: 2,  exp_ovf: 1'b0};
    vecs[1] = '{first: 8'h00, step: 8'h00, n_push: 0,  len: 3,  drain: 1'b1, exp_full: 1'b0, exp_rx: 3,  exp_ovf: 1'b0};
    vecs[2] = '{first: 8'h10, step: 8'h01, n_push: 17, len: 16, drain: 1'b0, exp_full: 1'b1, exp_rx: 0,  exp_ovf: 1'b0};
    vecs[3] = '{first: 8'h00, step: 8'h00, n_push: 0,  len: 1,  drain: 1'b1, exp_full: 1'b0, exp_rx: 16, exp_ovf: 1'b1};
    vecs[4] = '{first: 8'h00, step: 8'h00, n_push: 0,  len: 0,  drain: 1'b1, exp_full: 1'b0, exp_rx: 0,  exp_ovf: 1'b1};
    vecs[5] = '{first: 8'h5A, step: 8'h11, n_push: 3,  len: 3,  drain: 1'b1, exp_full: 1'b0, exp_rx: 3,  exp_ovf: 1'b0};

    rst = 1'b1; tx_stb = 1'b0; tx_data = 8'h00; rx_stb = 1'b0; start = 1'b0; len = 8'h00;
    model_reset();
    repeat (3) tick();
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_w_stb", 32'(spi_w_stb), 32'd0);
    check("rst_w_data", 32'(spi_w_data), 32'd0);
    check("rst_rx_ovf", 32'(rx_ovf), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    rst = 1'b0;
    tick();

    // Table of directed frames.
    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      for (int i = 0; i < vecs[v].n_push; i++) begin
        push_byte(8'(vecs[v].first + 8'(i) * vecs[v].step), 1'b1);
        check({nm, "_tx_full_push"}, 32'(tx_full), 32'(m_tx.size() == DEPTH));
      end
      check({nm, "_tx_full"}, 32'(tx_full), 32'(vecs[v].exp_full));
      begin_frame(vecs[v].len, d0, f0);
      finish_frame(nm, vecs[v].len, d0, f0);
      check({nm, "_ovf_tbl"}, 32'(rx_ovf), 32'(vecs[v].exp_ovf));
      if (vecs[v].drain) begin
        drain(nm, vecs[v].exp_rx);
        check({nm, "_rx_empty"}, 32'(rx_empty), 32'd1);
      end else begin
        check({nm, "_rx_empty"}, 32'(rx_empty), 32'd0);
      end
    end

    // START pulses while BUSY are ignored.
    push_byte(8'h31, 1'b1);
    push_byte(8'h32, 1'b1);
    begin_frame(2, d0, f0);
    repeat (20) tick();
    start = 1'b1;
    len = 8'd5;
    repeat (3) tick();
    start = 1'b0;
    finish_frame("busy_start", 2, d0, f0);
    drain("busy_start", 2);

    // LEN==0: DONE exactly one cycle after FIN entry, CS_N untouched.
    f0 = cs_fall_cnt;
    start = 1'b1;
    len = 8'd0;
    tick();
    start = 1'b0;
    check("len0_busy_fin", 32'(busy), 32'd1);
    check("len0_done_fin", 32'(done), 32'd0);
    tick();
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy_idle", 32'(busy), 32'd0);
    check("len0_cs_n", 32'(cs_n), 32'd1);
    tick();
    check("len0_done_once", 32'(done), 32'd0);
    check("len0_cs_falls", 32'(cs_fall_cnt - f0), 32'd0);

    // Reset in the middle of a 4-byte frame.
    for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + 8'(i)), 1'b1);
    sent_q.delete();
    start = 1'b1;
    len = 8'd4;
    tick();
    start = 1'b0;
    lim = 0;
    while (sent_q.size() == 0 && lim < 500) begin
      tick();
      lim++;
    end
    check("abort_first_byte", 32'(sent_q.size()), 32'd1);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_w_stb", 32'(spi_w_stb), 32'd0);
    check("abort_tx_full", 32'(tx_full), 32'd0);
    check("abort_rx_empty", 32'(rx_empty), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    w0 = wstb_cnt;
    repeat (200) tick();
    check("abort_no_w_stb", 32'(wstb_cnt - w0), 32'd0);
    begin_frame(1, d0, f0);
    finish_frame("after_abort", 1, d0, f0);
    drain("after_abort", 1);

    // Concurrent TX push and RX pop during a frame.
    for (int i = 0; i < 4; i++) push_byte(8'(8'h70 + 8'(i)), 1'b1);
    for (int i = 0; i < 4; i++) begin
      extra[i] = 8'(8'hE0 + 8'(i));
      model_push(extra[i]);
    end
    begin_frame(8, d0, f0);
    lim = 0;
    while (rx_empty && lim < 500) begin
      tick();
      lim++;
    end
    check("conc_first_rx", 32'(rx_empty), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tx_stb = 1'b1;
      tx_data = extra[k];
      if (!rx_empty) begin
        e = (m_rx.size() != 0) ? m_rx.pop_front() : 8'h00;
        check("conc_pop_data", 32'(rx_data), 32'(e));
        rx_stb = 1'b1;
      end
      tick();
      tx_stb = 1'b0;
      rx_stb = 1'b0;
    end
    check("conc_tx_full", 32'(tx_full), 32'd0);
    finish_frame("conc", 8, d0, f0);
    drain("conc", 7);

    // Randomized frames against the reference model.
    for (int f = 0; f < 6; f++) begin
      string nm;
      int np;
      int n;
      nm = $sformatf("rnd%0d", f);
      np = $urandom_range(0, 18);
      for (int i = 0; i < np; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
      check({nm, "_tx_full"}, 32'(tx_full), 32'(m_tx.size() == DEPTH));
      n = $urandom_range(0, 12);
      begin_frame(n, d0, f0);
      finish_frame(nm, n, d0, f0);
      if ($urandom_range(0, 2) != 0) drain(nm, m_rx.size());
      check({nm, "_rx_empty"}, 32'(rx_empty), 32'(m_rx.size() == 0));
    end

    check("protocol", 32'(proto_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_seq.md
Name: spi_frame_seq

Overview:
Multi-byte SPI transaction sequencer, directly upstream of SPI_cont.
- Host loads bytes into a TX FIFO, then issues START with a byte count.
- Block asserts CS_N and feeds SPI_cont one byte at a time over its W_STB/W_READY handshake.
- Each R_STB/R_DATA result from SPI_cont is collected into an RX FIFO.
- CS_N is released after the last byte and DONE is pulsed.

Parameters:
ADDR_WIDTH, 4, FIFO address width; each FIFO holds 2^ADDR_WIDTH bytes.
LEN_WIDTH, 8, width of the LEN byte-count input.
CS_DLY, 4, CLK cycles between CS_N fall and first W_STB, and between last R_STB and CS_N rise (min 1).
FILL, 8'hFF, byte sent when the TX FIFO is empty mid-frame.

Ports:
CLK  in  1  system clock, single clock domain
RST  in  1  asynchronous reset, active-high
TX_STB  in  1  push TX_DATA into TX FIFO
TX_DATA  in  8  byte to transmit
TX_FULL  out  1  TX FIFO full
RX_STB  in  1  pop RX FIFO; RX_DATA advances on the next cycle
RX_DATA  out  8  head of RX FIFO (first-word-fall-through)
RX_EMPTY  out  1  RX FIFO empty
RX_OVF  out  1  sticky flag: a received byte was dropped because the RX FIFO was full
START  in  1  begin a frame; sampled only in IDLE
LEN  in  LEN_WIDTH  bytes in the frame, latched on START
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse at frame end
CS_N  out  1  SPI chip select, active-low
SPI_W_STB  out  1  to SPI_cont W_STB
SPI_W_DATA  out  8  to SPI_cont W_DATA
SPI_W_READY  in  1  from SPI_cont W_READY
SPI_R_STB  in  1  from SPI_cont R_STB
SPI_R_DATA  in  8  from SPI_cont R_DATA

Behaviour:
Reset values:
- CS_N=1; BUSY, DONE, SPI_W_STB, RX_OVF all 0; SPI_W_DATA=0.
- Both FIFOs empty: TX_FULL=0, RX_EMPTY=1. State=IDLE.
- RST mid-frame: immediate abort with the same values; no W_STB is issued afterwards.

FSM states: IDLE, SETUP, SEND, WAIT_RX, HOLD, FIN.
- IDLE: on START with LEN!=0, latch remaining=LEN, clear RX_OVF, CS_N<=0, go to SETUP.
- IDLE, START with LEN==0: go straight to FIN; CS_N stays 1.
- SETUP: count CS_DLY cycles, then go to SEND.
- SEND: wait for SPI_W_READY=1. In that cycle register SPI_W_STB=1 for exactly one CLK with SPI_W_DATA = TX head (pop), or FILL if the TX FIFO is empty. Then go to WAIT_RX.
- WAIT_RX: on SPI_R_STB, push SPI_R_DATA to the RX FIFO and decrement remaining. Go to HOLD if remaining becomes 0, else SEND.
- HOLD: count CS_DLY cycles, then CS_N<=1 and go to FIN.
- FIN: DONE=1 for one cycle, then IDLE.

Handshake and FIFO rules:
- Only one byte is in flight; W_STB is never issued while waiting for R_STB.
- SPI_W_DATA returns to 0 when SPI_W_STB is low.
- START while BUSY is ignored.
- TX push when full: the byte is dropped and TX_FULL stays 1. RX pop when empty is ignored.
- Simultaneous push and pop on the same FIFO are both honoured; count is unchanged.
- RX push when full: byte dropped, RX_OVF<=1.
- TX pushes are allowed during a frame; they are consumed if they arrive before the byte is needed.
- FIFO pointers wrap modulo 2^ADDR_WIDTH. Count is ADDR_WIDTH+1 bits so full and empty are distinguished.
- LEN may exceed TX occupancy; excess bytes are sent as FILL (used for read-only transfers).

Decomposition:
- Shared package: FSM state encoding localparams, the FILL default, and the CS_DLY counter width derived via $clog2.
- Sub-module sync_fifo (WIDTH, ADDR_WIDTH): synchronous FWFT FIFO with FULL/EMPTY flags, async active-high reset. Instantiated twice, once for TX and once for RX.
- The top level holds the FSM, the remaining-byte counter and the delay counter.
- Bench instantiates spi_frame_seq feeding SPI_cont with TICK divider 5. The MISO slave model is a 16-bit shift register reset to 0x2963, shifted on the SCLK falling edge.

Test Plan:
- Push 0xAB, 0xCD; START with LEN=2 -> two SPI_W_STB pulses carrying 0xAB then 0xCD; RX FIFO pops 0x29 then 0x63. CS_N is low from SETUP to the end of HOLD; DONE pulses once; BUSY is low afterwards.
- TX FIFO empty; START with LEN=3 -> MOSI carries 0xFF three times; three RX bytes are stored; DONE pulses once.
- Push 17 bytes with ADDR_WIDTH=4 -> TX_FULL=1 after the 16th push and the 17th is dropped. Frame with LEN=16 sends 16 bytes; RX is full and RX_OVF=0. A second LEN=1 frame without popping sets RX_OVF=1.
- Assert START again while BUSY -> ignored: no extra bytes are sent and DONE pulses once. START with LEN=0 -> DONE one cycle after FIN entry; CS_N never goes low.
- Assert RST while in WAIT_RX of a 4-byte frame -> CS_N=1, BUSY=0, FIFOs empty, no further SPI_W_STB pulses. A fresh START with LEN=1 then completes normally.
- Push TX and pop RX in the same cycle during a frame -> both FIFO counts stay correct; data order is preserved (checked against a scoreboard).
